// File: rtl/stopwatch_timer_if.sv
// Stopwatch timer bus interface.
// Bundles the timer's command strobes, preset inputs and time/status outputs.
//   master : drives tick, start, stop, clear, load_en, load_min, load_sec,
//            mode and lap; observes every output.
//   slave  : the timer itself; drives time_out, lap_out, lap_valid, running,
//            expired and wrapped.
// MIN_W sets the minute field width. Time values are packed {min, sec},
// with seconds held in 6 bits.
interface stopwatch_timer_if #(
  parameter int MIN_W = 6
);
  logic             tick;
  logic             start;
  logic             stop;
  logic             clear;
  logic             load_en;
  logic [MIN_W-1:0] load_min;
  logic [5:0]       load_sec;
  logic             mode;
  logic             lap;
  logic [MIN_W+5:0] time_out;
  logic [MIN_W+5:0] lap_out;
  logic             lap_valid;
  logic             running;
  logic             expired;
  logic             wrapped;

  modport master (
    output tick, start, stop, clear, load_en, load_min, load_sec, mode, lap,
    input  time_out, lap_out, lap_valid, running, expired, wrapped
  );

  modport slave (
    input  tick, start, stop, clear, load_en, load_min, load_sec, mode, lap,
    output time_out, lap_out, lap_valid, running, expired, wrapped
  );
endinterface

// File: rtl/stopwatch_timer.sv
// Minutes:seconds stopwatch / countdown timer.
// Advances one step per 1 Hz tick while running, counting up or down.
// It supports start, pause, resume, preset load and lap capture. It flags
// expiry on reaching 00:00 (down) or the full-scale limit (up, no wrap).
// Ports:
//   clk  - system clock
//   nrst - asynchronous active-low reset
//   bus  - stopwatch_timer_if.slave. It carries the commands and presets
//          (tick, start, stop, clear, load_en, load_min, load_sec, mode, lap).
//          It also carries the registered outputs (time_out, lap_out,
//          lap_valid, running, expired, wrapped).
// Parameters:
//   MIN_W   - minute field width
//   MAX_MIN - largest minute value (< 2**MIN_W)
//   WRAP    - 1: count-up rolls MAX_MIN:59 -> 00:00 and keeps running
//             0: count-up holds at MAX_MIN:59 and stops in DONE
module stopwatch_timer #(
  parameter int MIN_W   = 6,
  parameter int MAX_MIN = 59,
  parameter bit WRAP    = 1'b0
) (
  input logic              clk,
  input logic              nrst,
  stopwatch_timer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);
  localparam logic [5:0]       SEC_MAX   = 6'd59;

  state_t           state;
  logic [MIN_W-1:0] min_q;
  logic [5:0]       sec_q;
  logic             mode_q;      // direction latched at start: 1 = down
  logic [MIN_W+5:0] lap_q;
  logic             lap_valid_q;
  logic             expired_q;
  logic             wrapped_q;
  logic             running_q;

  logic at_zero;
  logic start_cmd;
  logic stop_cmd;
  logic lap_ok;

  assign at_zero   = (min_q == '0) && (sec_q == '0);
  // A simultaneous start and stop cancel out.
  assign start_cmd = bus.start && !bus.stop;
  assign stop_cmd  = bus.stop && !bus.start;
  assign lap_ok    = bus.lap && !bus.clear && (state == RUN || state == PAUSED);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      min_q       <= '0;
      sec_q       <= '0;
      mode_q      <= 1'b0;
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
      expired_q   <= 1'b0;
      wrapped_q   <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout. Every branch below sees the
      // pre-edge min_q/sec_q, so the lap capture gets the pre-tick time.
      lap_valid_q <= 1'b0;
      expired_q   <= 1'b0;
      wrapped_q   <= 1'b0;

      if (lap_ok) begin
        lap_q       <= {min_q, sec_q};
        lap_valid_q <= 1'b1;
      end

      if (bus.clear) begin
        state     <= IDLE;
        running_q <= 1'b0;
        min_q     <= '0;
        sec_q     <= '0;
        lap_q     <= '0;
      end else if (bus.load_en && state != RUN) begin
        state     <= IDLE;
        running_q <= 1'b0;
        min_q     <= (bus.load_min > MAX_MIN_V) ? MAX_MIN_V : bus.load_min;
        sec_q     <= (bus.load_sec > SEC_MAX)   ? SEC_MAX   : bus.load_sec;
      end else begin
        case (state)
          IDLE, PAUSED: begin
            // Counting down from 00:00 would expire immediately, so the
            // start is refused.
            if (start_cmd && !(bus.mode && at_zero)) begin
              state     <= RUN;
              running_q <= 1'b1;
              mode_q    <= bus.mode;
            end
          end

          RUN: begin
            if (stop_cmd) begin
              state     <= PAUSED;
              running_q <= 1'b0;
            end else if (bus.tick) begin
              if (!mode_q) begin
                if (sec_q < SEC_MAX) begin
                  sec_q <= sec_q + 6'd1;
                end else if (min_q < MAX_MIN_V) begin
                  sec_q <= '0;
                  min_q <= min_q + 1'b1;
                end else if (WRAP) begin
                  sec_q     <= '0;
                  min_q     <= '0;
                  wrapped_q <= 1'b1;
                end else begin
                  state     <= DONE;
                  running_q <= 1'b0;
                  expired_q <= 1'b1;
                end
              end else begin
                if (sec_q != '0) begin
                  sec_q <= sec_q - 6'd1;
                  if (min_q == '0 && sec_q == 6'd1) begin
                    state     <= DONE;
                    running_q <= 1'b0;
                    expired_q <= 1'b1;
                  end
                end else if (min_q != '0) begin
                  sec_q <= SEC_MAX;
                  min_q <= min_q - 1'b1;
                end else begin
                  // Already at 00:00 while counting down; retire to DONE.
                  state     <= DONE;
                  running_q <= 1'b0;
                  expired_q <= 1'b1;
                end
              end
            end
          end

          default: ;  // DONE leaves only through clear or load_en
        endcase
      end
    end
  end

  assign bus.time_out  = {min_q, sec_q};
  assign bus.lap_out   = lap_q;
  assign bus.lap_valid = lap_valid_q;
  assign bus.running   = running_q;
  assign bus.expired   = expired_q;
  assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed testbench for stopwatch_timer.
// The main instance uses the defaults (59 minutes, hold at the limit). A
// second instance uses MAX_MIN = 1 and WRAP = 1 to reach the rollover quickly.
// Inputs change 1 time unit after a rising edge. Outputs are read at that
// same point, after the edge has updated them.
module tb_stopwatch_timer;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  stopwatch_timer_if #(.MIN_W(6)) b  ();
  stopwatch_timer_if #(.MIN_W(6)) b2 ();

  stopwatch_timer #(.MIN_W(6), .MAX_MIN(59), .WRAP(1'b0)) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (b.slave)
  );

  stopwatch_timer #(.MIN_W(6), .MAX_MIN(1), .WRAP(1'b1)) dut_wrap (
    .clk (clk),
    .nrst(nrst),
    .bus (b2.slave)
  );

  function automatic logic [11:0] tv(input int m, input int s);
    return {6'(m), 6'(s)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      b.tick = 1'b1;
      cyc();
      b.tick = 1'b0;
    end
  endtask

  task automatic cmd_start(input logic m);
    b.mode  = m;
    b.start = 1'b1;
    cyc();
    b.start = 1'b0;
  endtask

  task automatic cmd_stop();
    b.stop = 1'b1;
    cyc();
    b.stop = 1'b0;
  endtask

  task automatic cmd_clear();
    b.clear = 1'b1;
    cyc();
    b.clear = 1'b0;
  endtask

  task automatic cmd_load(input int m, input int s);
    b.load_min = 6'(m);
    b.load_sec = 6'(s);
    b.load_en  = 1'b1;
    cyc();
    b.load_en  = 1'b0;
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    #3;
    n_tests++;
    if ({b.time_out, b.lap_out, b.lap_valid, b.running, b.expired, b.wrapped} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset: outputs=%h expected 0", {b.time_out, b.lap_out, b.lap_valid, b.running, b.expired, b.wrapped});
    end
    n_tests++;
    if ({b2.time_out, b2.lap_out, b2.lap_valid, b2.running, b2.expired, b2.wrapped} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_wrap_inst: outputs=%h expected 0", {b2.time_out, b2.lap_out, b2.lap_valid, b2.running, b2.expired, b2.wrapped});
    end
    #10 nrst = 1'b1;
    cyc();
  endtask

  task automatic test_up_count();
    cmd_start(1'b0);
    n_tests++;
    if (b.running !== 1'b1) begin n_fail++; $display("FAIL up_running: got %b expected 1", b.running); end
    tick_n(59);
    n_tests++;
    if (b.time_out !== tv(0, 59)) begin n_fail++; $display("FAIL up_00_59: got %h expected %h", b.time_out, tv(0, 59)); end
    tick_n(1);
    n_tests++;
    if (b.time_out !== tv(1, 0)) begin n_fail++; $display("FAIL up_carry_01_00: got %h expected %h", b.time_out, tv(1, 0)); end
    tick_n(1);
    n_tests++;
    if (b.time_out !== tv(1, 1) || b.running !== 1'b1) begin
      n_fail++; $display("FAIL up_01_01: got %h run %b expected %h run 1", b.time_out, b.running, tv(1, 1));
    end
  endtask

  task automatic test_up_limit();
    cmd_clear();
    cmd_load(59, 58);
    n_tests++;
    if (b.time_out !== tv(59, 58) || b.running !== 1'b0) begin
      n_fail++; $display("FAIL limit_load: got %h run %b expected %h run 0", b.time_out, b.running, tv(59, 58));
    end
    cmd_start(1'b0);
    tick_n(1);
    n_tests++;
    if (b.time_out !== tv(59, 59) || b.expired !== 1'b0) begin
      n_fail++; $display("FAIL limit_59_59: got %h exp %b expected %h exp 0", b.time_out, b.expired, tv(59, 59));
    end
    tick_n(1);
    n_tests++;
    if (b.time_out !== tv(59, 59) || b.expired !== 1'b1 || b.running !== 1'b0) begin
      n_fail++; $display("FAIL limit_done: got %h exp %b run %b expected %h exp 1 run 0", b.time_out, b.expired, b.running, tv(59, 59));
    end
    cyc();
    n_tests++;
    if (b.expired !== 1'b0) begin n_fail++; $display("FAIL limit_expired_drop: got %b expected 0", b.expired); end
    tick_n(1);
    cmd_start(1'b0);
    n_tests++;
    if (b.time_out !== tv(59, 59) || b.running !== 1'b0 || b.expired !== 1'b0) begin
      n_fail++; $display("FAIL limit_hold: got %h run %b exp %b expected %h run 0 exp 0", b.time_out, b.running, b.expired, tv(59, 59));
    end
  endtask

  task automatic test_load_clamp();
    cmd_load(63, 63);
    n_tests++;
    if (b.time_out !== tv(59, 59) || b.running !== 1'b0) begin
      n_fail++; $display("FAIL load_clamp: got %h run %b expected %h run 0", b.time_out, b.running, tv(59, 59));
    end
  endtask

  task automatic test_down_count();
    cmd_load(0, 3);
    cmd_start(1'b1);
    n_tests++;
    if (b.running !== 1'b1) begin n_fail++; $display("FAIL down_running: got %b expected 1", b.running); end
    tick_n(2);
    n_tests++;
    if (b.time_out !== tv(0, 1) || b.expired !== 1'b0) begin
      n_fail++; $display("FAIL down_00_01: got %h exp %b expected %h exp 0", b.time_out, b.expired, tv(0, 1));
    end
    tick_n(1);
    n_tests++;
    if (b.time_out !== tv(0, 0) || b.expired !== 1'b1 || b.running !== 1'b0) begin
      n_fail++; $display("FAIL down_expire: got %h exp %b run %b expected 000 exp 1 run 0", b.time_out, b.expired, b.running);
    end
    cmd_start(1'b1);
    n_tests++;
    if (b.running !== 1'b0) begin n_fail++; $display("FAIL down_restart_ignored: got %b expected 0", b.running); end
    // Minute borrow, then mode input changes without a start.
    cmd_load(1, 0);
    cmd_start(1'b1);
    tick_n(1);
    n_tests++;
    if (b.time_out !== tv(0, 59)) begin n_fail++; $display("FAIL down_borrow: got %h expected %h", b.time_out, tv(0, 59)); end
    b.mode = 1'b0;
    tick_n(1);
    n_tests++;
    if (b.time_out !== tv(0, 58)) begin n_fail++; $display("FAIL mode_latched: got %h expected %h", b.time_out, tv(0, 58)); end
    cmd_clear();
    cmd_start(1'b1);
    n_tests++;
    if (b.running !== 1'b0) begin n_fail++; $display("FAIL down_zero_start: got %b expected 0", b.running); end
  endtask

  task automatic test_pause_resume();
    cmd_clear();
    cmd_start(1'b0);
    tick_n(10);
    cmd_stop();
    n_tests++;
    if (b.running !== 1'b0 || b.time_out !== tv(0, 10)) begin
      n_fail++; $display("FAIL pause_stop: got %h run %b expected %h run 0", b.time_out, b.running, tv(0, 10));
    end
    tick_n(5);
    n_tests++;
    if (b.time_out !== tv(0, 10)) begin n_fail++; $display("FAIL pause_hold: got %h expected %h", b.time_out, tv(0, 10)); end
    cmd_start(1'b0);
    tick_n(1);
    n_tests++;
    if (b.time_out !== tv(0, 11) || b.running !== 1'b1) begin
      n_fail++; $display("FAIL resume: got %h run %b expected %h run 1", b.time_out, b.running, tv(0, 11));
    end
  endtask

  task automatic test_lap();
    tick_n(9);
    b.lap  = 1'b1;
    b.tick = 1'b1;
    cyc();
    b.lap  = 1'b0;
    b.tick = 1'b0;
    n_tests++;
    if (b.lap_out !== tv(0, 20) || b.time_out !== tv(0, 21) || b.lap_valid !== 1'b1) begin
      n_fail++; $display("FAIL lap_capture: lap %h time %h valid %b expected %h %h 1", b.lap_out, b.time_out, b.lap_valid, tv(0, 20), tv(0, 21));
    end
    cyc();
    n_tests++;
    if (b.lap_valid !== 1'b0 || b.lap_out !== tv(0, 20)) begin
      n_fail++; $display("FAIL lap_pulse_drop: valid %b lap %h expected 0 %h", b.lap_valid, b.lap_out, tv(0, 20));
    end
  endtask

  task automatic test_priority();
    cmd_load(5, 5);
    n_tests++;
    if (b.time_out !== tv(0, 21) || b.running !== 1'b1) begin
      n_fail++; $display("FAIL load_in_run: got %h run %b expected %h run 1", b.time_out, b.running, tv(0, 21));
    end
    b.clear = 1'b1;
    b.load_en = 1'b1;
    b.start = 1'b1;
    cyc();
    b.clear = 1'b0;
    b.load_en = 1'b0;
    b.start = 1'b0;
    n_tests++;
    if (b.time_out !== 12'd0 || b.lap_out !== 12'd0 || b.running !== 1'b0) begin
      n_fail++; $display("FAIL clear_priority: time %h lap %h run %b expected 000 000 0", b.time_out, b.lap_out, b.running);
    end
  endtask

  task automatic test_async_reset();
    cmd_start(1'b0);
    tick_n(3);
    b.lap = 1'b1;
    cyc();
    b.lap = 1'b0;
    #2 nrst = 1'b0;
    #1;
    n_tests++;
    if ({b.time_out, b.lap_out, b.lap_valid, b.running, b.expired, b.wrapped} !== 28'd0) begin
      n_fail++; $display("FAIL async_reset: outputs=%h expected 0", {b.time_out, b.lap_out, b.lap_valid, b.running, b.expired, b.wrapped});
    end
    #3 nrst = 1'b1;
    cyc();
    tick_n(2);
    n_tests++;
    if (b.time_out !== 12'd0 || b.running !== 1'b0) begin
      n_fail++; $display("FAIL tick_after_reset: got %h run %b expected 000 run 0", b.time_out, b.running);
    end
  endtask

  task automatic test_wrap();
    b2.load_min = 6'd1;
    b2.load_sec = 6'd58;
    b2.load_en  = 1'b1;
    cyc();
    b2.load_en  = 1'b0;
    b2.mode     = 1'b0;
    b2.start    = 1'b1;
    cyc();
    b2.start    = 1'b0;
    b2.tick     = 1'b1;
    cyc();
    n_tests++;
    if (b2.time_out !== tv(1, 59) || b2.wrapped !== 1'b0) begin
      n_fail++; $display("FAIL wrap_01_59: got %h wr %b expected %h wr 0", b2.time_out, b2.wrapped, tv(1, 59));
    end
    cyc();
    b2.tick = 1'b0;
    n_tests++;
    if (b2.time_out !== 12'd0 || b2.wrapped !== 1'b1 || b2.running !== 1'b1 || b2.expired !== 1'b0) begin
      n_fail++; $display("FAIL wrap_rollover: got %h wr %b run %b exp %b expected 000 1 1 0", b2.time_out, b2.wrapped, b2.running, b2.expired);
    end
    cyc();
    n_tests++;
    if (b2.wrapped !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse_drop: got %b expected 0", b2.wrapped); end
    b2.tick = 1'b1;
    cyc();
    b2.tick = 1'b0;
    n_tests++;
    if (b2.time_out !== tv(0, 1)) begin n_fail++; $display("FAIL wrap_continue: got %h expected %h", b2.time_out, tv(0, 1)); end
  endtask

  initial begin
    {b.tick, b.start, b.stop, b.clear, b.load_en, b.mode, b.lap} = '0;
    b.load_min = '0;
    b.load_sec = '0;
    {b2.tick, b2.start, b2.stop, b2.clear, b2.load_en, b2.mode, b2.lap} = '0;
    b2.load_min = '0;
    b2.load_sec = '0;

    test_reset();
    test_up_count();
    test_up_limit();
    test_load_clamp();
    test_down_count();
    test_pause_resume();
    test_lap();
    test_priority();
    test_async_reset();
    test_wrap();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
